ahb_lite_master: RTL and testbench

//  AHB-Lite initiator: the master end of the bus served by the AHB slave memory top.

---
 rtl/ahb_lite_master.sv | 251 +++++++++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns valid/ready read/write commands (single or INCR bursts) into
// pipelined AHB address/data phases and returns one response per completed or errored beat.
module ahb_lite_master #(
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_BUS_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic                      wdata_valid,
    output logic                      wdata_ready,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_last,
    output logic [ADDR_BUS_WIDTH-1:0] HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [DATA_WIDTH-1:0]     HWDATA,
    input  logic [DATA_WIDTH-1:0]     HRDATA,
    input  logic                      HREADY,
    input  logic                      HRESP
);

    localparam logic [1:0] TR_IDLE      = 2'b00;
    localparam logic [1:0] TR_BUSY      = 2'b01;
    localparam logic [1:0] TR_NONSEQ    = 2'b10;
    localparam logic [1:0] TR_SEQ       = 2'b11;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] SIZE_WORD    = 3'b010;
    localparam int         CNT_W        = LEN_WIDTH + 1;
    localparam logic [CNT_W-1:0]          CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BUS_WIDTH-1:0] ADDR_STEP = {{(ADDR_BUS_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [ADDR_BUS_WIDTH-1:0] ALIGN_MASK = ~{{(ADDR_BUS_WIDTH-2){1'b0}}, 2'b11};

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_LAST_DATA, ST_ERR} state_t;

    state_t                    state_r, state_s;
    logic [ADDR_BUS_WIDTH-1:0] haddr_r, haddr_s, next_addr_r, next_addr_s, src_addr_s;
    logic [1:0]                htrans_r, htrans_s;
    logic                      hwrite_r, hwrite_s;
    logic [2:0]                hburst_r, hburst_s, burst_r, burst_s, src_burst_s;
    logic [DATA_WIDTH-1:0]     hwdata_r, hwdata_s, wbuf_r, wbuf_s;
    logic [CNT_W-1:0]          issue_cnt_r, issue_cnt_s, src_cnt_s;
    logic                      first_r, first_s, cmd_write_r, cmd_write_s;
    logic                      addr_last_r, addr_last_s;
    logic                      dp_valid_r, dp_valid_s, dp_write_r, dp_write_s, dp_last_r, dp_last_s;
    logic                      rsp_valid_r, rsp_valid_s, rsp_err_r, rsp_err_s, rsp_last_r, rsp_last_s;
    logic [DATA_WIDTH-1:0]     rsp_rdata_r, rsp_rdata_s;
    logic                      accept_s, in_burst_s, src_pending_s, src_write_s, src_first_s;
    logic                      issue_s, err_first_s, addr_acc_s, wdata_ready_s;

    assign cmd_ready   = (state_r == ST_IDLE) && HRESETn;
    assign wdata_ready = wdata_ready_s && HRESETn;
    assign HADDR       = haddr_r;
    assign HTRANS      = htrans_r;
    assign HWRITE      = hwrite_r;
    assign HSIZE       = SIZE_WORD;
    assign HBURST      = hburst_r;
    assign HWDATA      = hwdata_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_last    = rsp_last_r;

    // Next-state, bus phase sequencing and response generation; everything holds unless updated.
    always_comb begin
        state_s     = state_r;
        haddr_s     = haddr_r;
        htrans_s    = htrans_r;
        hwrite_s    = hwrite_r;
        hburst_s    = hburst_r;
        hwdata_s    = hwdata_r;
        wbuf_s      = wbuf_r;
        next_addr_s = next_addr_r;
        issue_cnt_s = issue_cnt_r;
        first_s     = first_r;
        cmd_write_s = cmd_write_r;
        burst_s     = burst_r;
        addr_last_s = addr_last_r;
        dp_valid_s  = dp_valid_r;
        dp_write_s  = dp_write_r;
        dp_last_s   = dp_last_r;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = {DATA_WIDTH{1'b0}};
        rsp_err_s   = 1'b0;
        rsp_last_s  = 1'b0;

        accept_s   = (state_r == ST_IDLE) && cmd_valid;
        in_burst_s = (state_r == ST_ADDR) || (state_r == ST_LAST_DATA);
        // The first beat can issue in the very cycle the command is accepted.
        if (accept_s) begin
            src_pending_s = 1'b1;
            src_addr_s    = cmd_addr & ALIGN_MASK;
            src_write_s   = cmd_write;
            src_first_s   = 1'b1;
            src_cnt_s     = {1'b0, cmd_len} + CNT_ONE;
            src_burst_s   = (cmd_len == {LEN_WIDTH{1'b0}}) ? BURST_SINGLE : BURST_INCR;
        end else begin
            src_pending_s = (state_r == ST_ADDR) && (issue_cnt_r != {CNT_W{1'b0}});
            src_addr_s    = next_addr_r;
            src_write_s   = cmd_write_r;
            src_first_s   = first_r;
            src_cnt_s     = issue_cnt_r;
            src_burst_s   = burst_r;
        end
        issue_s     = HREADY && src_pending_s && (!src_write_s || wdata_valid);
        err_first_s = HRESP && !HREADY && dp_valid_r && in_burst_s;
        addr_acc_s  = HREADY && ((htrans_r == TR_NONSEQ) || (htrans_r == TR_SEQ));

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s     = ST_ADDR;
                    cmd_write_s = cmd_write;
                    burst_s     = src_burst_s;
                    next_addr_s = src_addr_s;
                    issue_cnt_s = src_cnt_s;
                    first_s     = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR, ST_LAST_DATA: begin
                if (err_first_s) begin
                    state_s     = ST_ERR;
                    htrans_s    = TR_IDLE;
                    issue_cnt_s = {CNT_W{1'b0}};
                    dp_valid_s  = 1'b0;
                end else if (HREADY) begin
                    rsp_valid_s = dp_valid_r;
                    rsp_rdata_s = (dp_valid_r && !dp_write_r) ? HRDATA : {DATA_WIDTH{1'b0}};
                    rsp_last_s  = dp_valid_r && dp_last_r;
                    dp_valid_s  = addr_acc_s;
                    dp_write_s  = hwrite_r;
                    dp_last_s   = addr_last_r;
                    if (addr_acc_s && hwrite_r) begin
                        hwdata_s = wbuf_r;
                    end else begin
                        hwdata_s = hwdata_r;
                    end
                    if (state_r == ST_LAST_DATA) begin
                        state_s = ST_IDLE;
                    end else if (addr_acc_s && addr_last_r) begin
                        state_s = ST_LAST_DATA;
                    end else begin
                        state_s = ST_ADDR;
                    end
                    // Write data starved: BUSY mid-burst, plain IDLE before the first beat.
                    if (src_pending_s && !first_r) begin
                        htrans_s = TR_BUSY;
                        haddr_s  = next_addr_r;
                    end else begin
                        htrans_s = TR_IDLE;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_ERR: begin
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b1;
                rsp_last_s  = 1'b1;
                state_s     = ST_IDLE;
            end
            default: begin
                state_s  = ST_IDLE;
                htrans_s = TR_IDLE;
            end
        endcase

        if (issue_s) begin
            wdata_ready_s = src_write_s;
            haddr_s       = src_addr_s;
            htrans_s      = (src_first_s || (src_addr_s[9:0] == 10'd0)) ? TR_NONSEQ : TR_SEQ;
            hwrite_s      = src_write_s;
            hburst_s      = src_burst_s;
            wbuf_s        = src_write_s ? wdata : wbuf_r;
            next_addr_s   = src_addr_s + ADDR_STEP;
            issue_cnt_s   = src_cnt_s - CNT_ONE;
            addr_last_s   = (src_cnt_s == CNT_ONE);
            first_s       = 1'b0;
        end else begin
            wdata_ready_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered bus outputs, burst bookkeeping and responses.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_r     <= {ADDR_BUS_WIDTH{1'b0}};
            htrans_r    <= TR_IDLE;
            hwrite_r    <= 1'b0;
            hburst_r    <= BURST_SINGLE;
            hwdata_r    <= {DATA_WIDTH{1'b0}};
            wbuf_r      <= {DATA_WIDTH{1'b0}};
            next_addr_r <= {ADDR_BUS_WIDTH{1'b0}};
            issue_cnt_r <= {CNT_W{1'b0}};
            first_r     <= 1'b0;
            cmd_write_r <= 1'b0;
            burst_r     <= BURST_SINGLE;
            addr_last_r <= 1'b0;
            dp_valid_r  <= 1'b0;
            dp_write_r  <= 1'b0;
            dp_last_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
            rsp_last_r  <= 1'b0;
        end else begin
            haddr_r     <= haddr_s;
            htrans_r    <= htrans_s;
            hwrite_r    <= hwrite_s;
            hburst_r    <= hburst_s;
            hwdata_r    <= hwdata_s;
            wbuf_r      <= wbuf_s;
            next_addr_r <= next_addr_s;
            issue_cnt_r <= issue_cnt_s;
            first_r     <= first_s;
            cmd_write_r <= cmd_write_s;
            burst_r     <= burst_s;
            addr_last_r <= addr_last_s;
            dp_valid_r  <= dp_valid_s;
            dp_write_r  <= dp_write_s;
            dp_last_r   <= dp_last_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            rsp_last_r  <= rsp_last_s;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: the bench plays the slave cycle by cycle and checks
// the bus and response ports against hand-computed values.
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [31:0] wdata;
    logic        wdata_valid, wdata_ready;
    logic        rsp_valid, rsp_err, rsp_last;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;

    int vectors     = 0;
    int miscompares = 0;

    ahb_lite_master #(.ADDR_BUS_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_last(rsp_last),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d,
                           input logic e, input logic l);
        chk({tag, ".valid"}, {31'd0, rsp_valid}, {31'd0, v});
        chk({tag, ".rdata"}, rsp_rdata, d);
        chk({tag, ".err"},   {31'd0, rsp_err},   {31'd0, e});
        chk({tag, ".last"},  {31'd0, rsp_last},  {31'd0, l});
    endtask

    task automatic chk_bus(input string tag, input logic [1:0] tr, input logic [31:0] a);
        chk({tag, ".htrans"}, {30'd0, HTRANS}, {30'd0, tr});
        chk({tag, ".haddr"},  HADDR, a);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 4'd0;
        wdata = 32'd0; wdata_valid = 1'b0; HRDATA = 32'd0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        chk_bus("reset", 2'b00, 32'd0);
        chk("reset.hsize",  {29'd0, HSIZE},  32'd2);
        chk("reset.hburst", {29'd0, HBURST}, 32'd0);
        chk("reset.hwdata", HWDATA, 32'd0);
        chk("reset.hwrite", {31'd0, HWRITE}, 32'd0);
        chk_rsp("reset", 1'b0, 32'd0, 1'b0, 1'b0);
        chk("reset.cmd_ready", {31'd0, cmd_ready}, 32'd0);
        HRESETn = 1'b1;
        #1;
        chk("release.cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // 1: read single @0x010
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h010; cmd_len = 4'd0;
        tick();
        cmd_valid = 1'b0;
        chk_bus("t1.c1", 2'b10, 32'h010);
        chk("t1.c1.hburst", {29'd0, HBURST}, 32'd0);
        chk("t1.c1.cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        HRDATA = 32'hCAFE_0001;
        chk("t1.c2.htrans", {30'd0, HTRANS}, 32'd0);
        chk("t1.c2.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        HRDATA = 32'd0;
        chk_rsp("t1.c3", 1'b1, 32'hCAFE_0001, 1'b0, 1'b1);
        chk("t1.c3.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        chk("t1.c4.rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // 2: write INCR len=3 @0x100, data always valid
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_len = 4'd3;
        wdata_valid = 1'b1; wdata = 32'hA0;
        #1;
        chk("t2.c0.wdata_ready", {31'd0, wdata_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0; wdata = 32'hA1;
        chk_bus("t2.c1", 2'b10, 32'h100);
        chk("t2.c1.hburst", {29'd0, HBURST}, 32'd1);
        chk("t2.c1.hwrite", {31'd0, HWRITE}, 32'd1);
        tick();
        wdata = 32'hA2;
        chk_bus("t2.c2", 2'b11, 32'h104);
        chk("t2.c2.hwdata", HWDATA, 32'hA0);
        tick();
        wdata = 32'hA3;
        chk_bus("t2.c3", 2'b11, 32'h108);
        chk("t2.c3.hwdata", HWDATA, 32'hA1);
        chk_rsp("t2.c3", 1'b1, 32'd0, 1'b0, 1'b0);
        tick();
        wdata_valid = 1'b0;
        #1;
        chk_bus("t2.c4", 2'b11, 32'h10C);
        chk("t2.c4.hwdata", HWDATA, 32'hA2);
        chk("t2.c4.wdata_ready", {31'd0, wdata_ready}, 32'd0);
        chk_rsp("t2.c4", 1'b1, 32'd0, 1'b0, 1'b0);
        tick();
        chk("t2.c5.htrans", {30'd0, HTRANS}, 32'd0);
        chk("t2.c5.hwdata", HWDATA, 32'hA3);
        chk_rsp("t2.c5", 1'b1, 32'd0, 1'b0, 1'b0);
        tick();
        chk_rsp("t2.c6", 1'b1, 32'd0, 1'b0, 1'b1);
        chk("t2.c6.cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // 3: read len=3 @0x3F8 crossing the 1KB boundary
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3F8; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        chk_bus("t3.c1", 2'b10, 32'h3F8);
        tick();
        HRDATA = 32'h1000_0000;
        chk_bus("t3.c2", 2'b11, 32'h3FC);
        tick();
        HRDATA = 32'h1000_0001;
        chk_bus("t3.c3", 2'b10, 32'h400);
        chk_rsp("t3.c3", 1'b1, 32'h1000_0000, 1'b0, 1'b0);
        tick();
        HRDATA = 32'h1000_0002;
        chk_bus("t3.c4", 2'b11, 32'h404);
        chk("t3.c4.hburst", {29'd0, HBURST}, 32'd1);
        chk_rsp("t3.c4", 1'b1, 32'h1000_0001, 1'b0, 1'b0);
        tick();
        HRDATA = 32'h1000_0003;
        chk_rsp("t3.c5", 1'b1, 32'h1000_0002, 1'b0, 1'b0);
        tick();
        HRDATA = 32'd0;
        chk_rsp("t3.c6", 1'b1, 32'h1000_0003, 1'b0, 1'b1);

        // 4: write len=2 @0x200 with a two-cycle write-data stall after beat0
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h200; cmd_len = 4'd2;
        wdata_valid = 1'b1; wdata = 32'hB0;
        tick();
        cmd_valid = 1'b0; wdata_valid = 1'b0;
        #1;
        chk_bus("t4.c1", 2'b10, 32'h200);
        chk("t4.c1.wdata_ready", {31'd0, wdata_ready}, 32'd0);
        tick();
        chk_bus("t4.c2", 2'b01, 32'h204);
        chk("t4.c2.hwdata", HWDATA, 32'hB0);
        tick();
        wdata_valid = 1'b1; wdata = 32'hB1;
        #1;
        chk_bus("t4.c3", 2'b01, 32'h204);
        chk_rsp("t4.c3", 1'b1, 32'd0, 1'b0, 1'b0);
        chk("t4.c3.wdata_ready", {31'd0, wdata_ready}, 32'd1);
        tick();
        wdata = 32'hB2;
        chk_bus("t4.c4", 2'b11, 32'h204);
        chk("t4.c4.hwdata", HWDATA, 32'hB0);
        tick();
        wdata_valid = 1'b0;
        chk_bus("t4.c5", 2'b11, 32'h208);
        chk("t4.c5.hwdata", HWDATA, 32'hB1);
        tick();
        chk("t4.c6.hwdata", HWDATA, 32'hB2);
        chk_rsp("t4.c6", 1'b1, 32'd0, 1'b0, 1'b0);
        tick();
        chk_rsp("t4.c7", 1'b1, 32'd0, 1'b0, 1'b1);

        // 5: read len=3 @0x800, slave errors beat0
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h800; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        chk_bus("t5.c1", 2'b10, 32'h800);
        tick();
        HREADY = 1'b0; HRESP = 1'b1;
        chk_bus("t5.c2", 2'b11, 32'h804);
        tick();
        HREADY = 1'b1; HRESP = 1'b1;
        chk("t5.c3.htrans", {30'd0, HTRANS}, 32'd0);
        chk("t5.c3.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        HRESP = 1'b0;
        chk_rsp("t5.c4", 1'b1, 32'd0, 1'b1, 1'b1);
        tick();
        chk("t5.c5.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t5.c5.htrans", {30'd0, HTRANS}, 32'd0);
        chk("t5.c5.cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // 6: reset asserted mid-burst during a wait state
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h040; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0;
        chk_bus("t6.c2", 2'b11, 32'h044);
        tick();
        chk_bus("t6.wait", 2'b11, 32'h044);
        chk("t6.wait.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        HRESETn = 1'b0;
        #1;
        chk_bus("t6.rst", 2'b00, 32'd0);
        chk("t6.rst.hburst", {29'd0, HBURST}, 32'd0);
        chk("t6.rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        HRESETn = 1'b1; HREADY = 1'b1;
        #1;
        chk("t6.rel.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t6.rel.htrans", {30'd0, HTRANS}, 32'd0);
        tick();
        chk("t6.post.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t6.post.htrans", {30'd0, HTRANS}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
